// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The fetch FIFO and the top-level fetch control both import this package.
package ifetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam int FIFO_DEPTH = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Pointer advance for a ring whose depth is not a power of two.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Three-entry ring buffer of {pc, inst} pairs between the ROM return path and
// the consumer. Flush has priority over push and pop in the same cycle.
module fetch_fifo
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst,
  output logic [1:0]  count
);

  fetch_entry_t mem_q [FIFO_DEPTH];
  fetch_entry_t mem_d [FIFO_DEPTH];
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

    if (flush) begin
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      count_d  = 2'd0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push) begin
        mem_d[wr_ptr_q] = '{pc: push_pc, inst: push_inst};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  // Control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage: contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_pc   = mem_q[rd_ptr_q].pc;
  assign head_inst = mem_q[rd_ptr_q].inst;
  assign count     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Sequential instruction fetch from a registered-read ROM into a small output
// FIFO, with redirect and a sticky fault for misaligned or out-of-range targets.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [XLEN-1:0] ROM_LIMIT = XLEN'(ROM_BYTES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic [1:0]      fifo_count;
  logic [1:0]      cnt_after_pop;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_inst;
  logic            room;
  logic            pc_oob;

  assign out_valid = (fifo_count != 2'd0) && (state_q == RUN);
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_push = inflight_q && (state_q == RUN);

  // Room is judged against occupancy after this cycle's pop plus the word
  // still travelling back from the ROM, so the FIFO can never overflow.
  assign cnt_after_pop = fifo_count - 2'(fifo_pop);
  assign room   = (3'(cnt_after_pop) + 3'(inflight_q)) < 3'(FIFO_DEPTH);
  assign pc_oob = pc_q >= ROM_LIMIT;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fault_pc_d    = fault_pc_q;
    fifo_flush    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          fifo_flush = 1'b1;
          pc_d       = redirect_pc;
          if ((redirect_pc[1:0] != 2'b00) || (redirect_pc >= ROM_LIMIT)) begin
            state_d    = FAULT;
            fault_pc_d = redirect_pc;
          end
        end else if (room) begin
          if (!pc_oob) begin
            pc_d          = pc_q + XLEN'(INST_BYTES);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
          end else if (!inflight_q && (cnt_after_pop == 2'd0)) begin
            // Running off the end of the ROM only faults once everything
            // fetched before it has been handed to the consumer.
            state_d    = FAULT;
            fault_pc_d = pc_q;
          end
        end
      end
      FAULT: begin
        fifo_flush = 1'b1;
      end
    endcase
  end

  // Control state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Address of the word in flight; only consumed while inflight_q is set
  always_ff @(posedge CLK) begin
    inflight_pc_q <= inflight_pc_d;
  end

  fetch_fifo u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (fifo_push),
    .push_pc   (inflight_pc_q),
    .push_inst (rom_q),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (fifo_count)
  );

  assign rom_addr = pc_q;
  assign out_pc   = out_valid ? head_pc : '0;
  assign out_inst = out_valid ? head_inst : '0;
  assign fault    = (state_q == FAULT);
  assign fault_pc = fault_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a 4 KiB-window instance for streaming, stall,
// redirect and reset scenarios, plus a 16-byte-window instance for wrap fault.
module tb_inst_fetch;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr, rom_q, out_pc, out_inst, fault_pc;
  logic        out_valid, fault;

  logic        redirect_valid16;
  logic [31:0] redirect_pc16;
  logic [31:0] rom_addr16, rom_q16, out_pc16, out_inst16, fault_pc16;
  logic        out_valid16, fault16;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  inst_fetch dut (
    .CLK(CLK), .RST(RST), .rom_addr(rom_addr), .rom_q(rom_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .fault(fault), .fault_pc(fault_pc)
  );

  inst_fetch #(.RESET_PC(32'h0), .ROM_BYTES(16)) dut16 (
    .CLK(CLK), .RST(RST), .rom_addr(rom_addr16), .rom_q(rom_q16),
    .redirect_valid(redirect_valid16), .redirect_pc(redirect_pc16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_pc(out_pc16),
    .out_inst(out_inst16), .fault(fault16), .fault_pc(fault_pc16)
  );

  // ROM model: word i holds A000_0000 + i, one cycle read latency
  always @(posedge CLK) begin
    rom_q   <= 32'hA000_0000 + (rom_addr >> 2);
    rom_q16 <= 32'hA000_0000 + (rom_addr16 >> 2);
  end

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    redirect_valid16 = 1'b0; redirect_pc16 = '0;
    cyc(); cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
    checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc got %h want 0", fault_pc); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got %h want 0", out_inst); end
    checks++; if (fault16 !== 1'b0) begin errors++; $display("FAIL reset_fault16 got %0b want 0", fault16); end
  endtask

  task automatic test_stream();
    RST = 1'b0;
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL stream_first_addr got %h want 0", rom_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_valid got %0b want 0", out_valid); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %0b want 0", out_valid); end
    checks++; if (rom_addr !== 32'h4) begin errors++; $display("FAIL stream_c1_addr got %h want 4", rom_addr); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, out_pc, 32'(4 * i)); end
      checks++; if (out_inst !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL stream_inst[%0d] got %h want %h", i, out_inst, 32'hA000_0000 + 32'(i)); end
    end
    exp_pc = 32'h20;
  endtask

  task automatic test_backpressure();
    for (int s = 0; s < 6; s++) begin
      cyc();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %0b want 1", s, out_valid); end
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL stall_pc[%0d] got %h want %h", s, out_pc, exp_pc); end
      if (s >= 1) begin
        checks++; if (rom_addr !== exp_pc + 32'd12) begin errors++; $display("FAIL stall_addr[%0d] got %h want %h", s, rom_addr, exp_pc + 32'd12); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      out_ready = 1'b1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL release_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL release_pc[%0d] got %h want %h", i, out_pc, exp_pc); end
      checks++; if (out_inst !== 32'hA000_0000 + (exp_pc >> 2)) begin errors++; $display("FAIL release_inst[%0d] got %h want %h", i, out_inst, 32'hA000_0000 + (exp_pc >> 2)); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    checks++; if (out_pc !== exp_pc) begin errors++; $display("FAIL redir_active_pc got %h want %h", out_pc, exp_pc); end
    cyc();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_r1_valid got %0b want 0", out_valid); end
    checks++; if (rom_addr !== 32'h40) begin errors++; $display("FAIL redir_r1_addr got %h want 40", rom_addr); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_r2_valid got %0b want 0", out_valid); end
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL redir_r3_valid got %0b want 1", out_valid); end
    checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL redir_r3_pc got %h want 40", out_pc); end
    checks++; if (out_inst !== 32'hA000_0010) begin errors++; $display("FAIL redir_r3_inst got %h want a0000010", out_inst); end
    cyc();
    checks++; if (out_pc !== 32'h44) begin errors++; $display("FAIL redir_r4_pc got %h want 44", out_pc); end
    checks++; if (out_inst !== 32'hA000_0011) begin errors++; $display("FAIL redir_r4_inst got %h want a0000011", out_inst); end
  endtask

  task automatic test_fault_redirect();
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    cyc();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL misalign_fault got %0b want 1", fault); end
    checks++; if (fault_pc !== 32'h42) begin errors++; $display("FAIL misalign_fault_pc got %h want 42", fault_pc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL misalign_valid got %0b want 0", out_valid); end
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    cyc();
    redirect_valid = 1'b0;
    repeat (3) cyc();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL sticky_fault got %0b want 1", fault); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sticky_valid got %0b want 0", out_valid); end
    checks++; if (fault_pc !== 32'h42) begin errors++; $display("FAIL sticky_fault_pc got %h want 42", fault_pc); end
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_clears_fault got %0b want 0", fault); end
    checks++; if (fault_pc !== 32'h0) begin errors++; $display("FAIL rst_clears_fault_pc got %h want 0", fault_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h1000;
    cyc();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL range_fault got %0b want 1", fault); end
    checks++; if (fault_pc !== 32'h1000) begin errors++; $display("FAIL range_fault_pc got %h want 1000", fault_pc); end
  endtask

  task automatic test_reset_midstream();
    RST = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    cyc();
    RST = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill_valid got %0b want 1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL mid_prefill_pc got %h want 0", out_pc); end
    RST = 1'b1;
    cyc();
    RST = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_rst_valid got %0b want 0", out_valid); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL mid_after_rst_addr got %h want 0", rom_addr); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %0b want 0", out_valid); end
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_valid got %0b want 1", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL mid_restart_pc got %h want 0", out_pc); end
    checks++; if (out_inst !== 32'hA000_0000) begin errors++; $display("FAIL mid_restart_inst got %h want a0000000", out_inst); end
    cyc();
    checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL mid_restart_pc2 got %h want 4", out_pc); end
  endtask

  task automatic test_wrap();
    RST = 1'b1; out_ready = 1'b1;
    cyc();
    RST = 1'b0;
    checks++; if (rom_addr16 !== 32'h0) begin errors++; $display("FAIL wrap_c0_addr got %h want 0", rom_addr16); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (out_valid16 !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d] got %0b want 1", i, out_valid16); end
      checks++; if (out_pc16 !== 32'(4 * i)) begin errors++; $display("FAIL wrap_pc[%0d] got %h want %h", i, out_pc16, 32'(4 * i)); end
      checks++; if (out_inst16 !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL wrap_inst[%0d] got %h want %h", i, out_inst16, 32'hA000_0000 + 32'(i)); end
      checks++; if (fault16 !== 1'b0) begin errors++; $display("FAIL wrap_early_fault[%0d] got %0b want 0", i, fault16); end
    end
    cyc();
    checks++; if (fault16 !== 1'b1) begin errors++; $display("FAIL wrap_fault got %0b want 1", fault16); end
    checks++; if (fault_pc16 !== 32'h10) begin errors++; $display("FAIL wrap_fault_pc got %h want 10", fault_pc16); end
    checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL wrap_valid_after got %0b want 0", out_valid16); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault_redirect();
    test_reset_midstream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
